// File: rtl/jkff_bank_arbiter.sv
// Round-robin arbiter that applies hold/reset/set/toggle commands from N_REQ requesters
// to a BANK_W-bit JK flip-flop bank, with one command accepted every two cycles.
module jkff_bank_arbiter #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned BANK_W = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [2*N_REQ-1:0]        req_op,
  input  logic [N_REQ*BANK_W-1:0]   req_mask,
  output logic [N_REQ-1:0]          grant,
  output logic                      busy,
  output logic [BANK_W-1:0]         j_drv,
  output logic [BANK_W-1:0]         k_drv,
  output logic [BANK_W-1:0]         q
);

  localparam int unsigned IDX_W = (N_REQ > 2) ? $clog2(N_REQ) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    APPLY = 1'b1
  } state_t;

  state_t              state;
  logic [IDX_W-1:0]    ptr;
  logic [IDX_W-1:0]    ptr_nxt;
  logic [IDX_W-1:0]    win_idx;
  logic [IDX_W-1:0]    cand;
  logic [IDX_W:0]      cand_sum;
  logic                found;
  logic [1:0]          win_op;
  logic [BANK_W-1:0]   win_mask;

  // Round-robin search starting at ptr, wrapping from N_REQ-1 back to 0
  always_comb begin
    found    = 1'b0;
    win_idx  = '0;
    cand_sum = '0;
    cand     = '0;
    if (!rst && state == IDLE) begin
      for (int k = 0; k < int'(N_REQ); k++) begin
        cand_sum = {1'b0, ptr} + (IDX_W+1)'(k);
        if (cand_sum >= (IDX_W+1)'(N_REQ)) begin
          cand_sum = cand_sum - (IDX_W+1)'(N_REQ);
        end
        cand = cand_sum[IDX_W-1:0];
        if (!found && req[cand]) begin
          found   = 1'b1;
          win_idx = cand;
        end
      end
    end
  end

  // One-hot grant plus the winner's command fields
  always_comb begin
    grant    = '0;
    win_op   = '0;
    win_mask = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (found && win_idx == IDX_W'(i)) begin
        grant[i] = 1'b1;
        win_op   = req_op[2*i +: 2];
        win_mask = req_mask[i*BANK_W +: BANK_W];
      end
    end
  end

  always_comb begin
    ptr_nxt = (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
  end

  // Command FSM: capture the winner into the J/K drives, then release them
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      busy  <= 1'b0;
      j_drv <= '0;
      k_drv <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state <= APPLY;
            busy  <= 1'b1;
            ptr   <= ptr_nxt;
            j_drv <= win_mask & {BANK_W{win_op[1]}};
            k_drv <= win_mask & {BANK_W{win_op[0]}};
          end
        end
        APPLY: begin
          state <= IDLE;
          busy  <= 1'b0;
          j_drv <= '0;
          k_drv <= '0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          j_drv <= '0;
          k_drv <= '0;
        end
      endcase
    end
  end

  // JK bank; drives are zero outside APPLY so the bank holds while idle
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else begin
      q <= (j_drv & ~q) | (~k_drv & q);
    end
  end

endmodule

// File: doc/jkff_bank_arbiter.md
JKFF_BANK_ARBITER -- requirements
Module: jkff_bank_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters (minimum 2).
REQ-002 Parameter BANK_W, default 8: width of the JK flip-flop bank.
REQ-003 clk  input  1  rising-edge clock; the only clock in the block.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 req  input  N_REQ  per-requester command request; held high until granted.
REQ-006 req_op  input  2*N_REQ  per-requester opcode; requester i uses bits [2i+1:2i].
- 00 = hold
- 01 = reset
- 10 = set
- 11 = toggle
REQ-007 req_mask  input  N_REQ*BANK_W  per-requester bit-select mask; requester i uses bits [(i+1)*BANK_W-1:i*BANK_W].
REQ-008 grant  output  N_REQ  one-hot acceptance, combinational.
REQ-009 busy  output  1  high while a command is being applied.
REQ-010 j_drv, k_drv  output  BANK_W each  registered J and K drives to the bank.
REQ-011 q  output  BANK_W  current bank state.

Function
REQ-012 The block SHALL contain a BANK_W-bit bank of JK flip-flops; each bit updates on the clock edge only from its j_drv/k_drv pair.
- J=0, K=0: hold
- J=0, K=1: clear to 0
- J=1, K=0: set to 1
- J=1, K=1: toggle
REQ-013 FSM states SHALL be IDLE and APPLY.
- IDLE -> APPLY when any req bit is high.
- APPLY -> IDLE unconditionally.
- Throughput is one command per 2 cycles.
REQ-014 In IDLE, grant SHALL be one-hot for the round-robin winner among the high req bits, else all zero. In APPLY, grant SHALL be all zero.
REQ-015 A transfer SHALL occur on the edge where req[i] and grant[i] are both high. On that edge the winner's op and mask are captured into j_drv/k_drv per bit:
- mask bit 0 -> J=0, K=0
- op 00 -> J=0, K=0
- op 01 -> J=0, K=1
- op 10 -> J=1, K=0
- op 11 -> J=1, K=1
REQ-016 In APPLY, busy SHALL be 1. The bank SHALL update from j_drv/k_drv on the edge ending APPLY.
REQ-017 On the edge ending APPLY, j_drv/k_drv SHALL return to all zero, so the bank holds while IDLE.
REQ-018 Latency: with the grant in cycle c, the new q SHALL be visible in cycle c+2.
REQ-019 Round-robin pointer behaviour:
- The search starts at pointer p and proceeds upward with wrap-around from N_REQ-1 to 0.
- After a grant to index i, p = (i+1) mod N_REQ.
- p is unchanged when no grant occurs.
REQ-020 A requester that drops req before it is granted SHALL be ignored, with no partial effect. op/mask changes while req is high and not yet granted SHALL be taken as-is at the grant edge.
REQ-021 Requests arriving during APPLY SHALL wait; no request is lost or reordered beyond the round-robin rule.
REQ-022 Unused mask bits SHALL be respected independently per bit; mask 0 with any op SHALL leave q unchanged but still consume a grant.

Reset
REQ-023 While rst=1 at an edge, the block SHALL set the following, and grant SHALL be 0 during any cycle with rst=1:
- state = IDLE
- q = 0
- j_drv = 0, k_drv = 0
- busy = 0
- p = 0
REQ-024 Reset asserted during APPLY SHALL abort the command: q SHALL be 0 after the edge, with no set/toggle effect. The first grant after reset SHALL use p=0.

Verification
REQ-025 Reset: hold rst=1 for 2 cycles with req=4'b1111 -> grant=0, busy=0, q=8'h00, j_drv=k_drv=8'h00 throughout.
REQ-026 Set/latency: in cycle c, req=4'b0001 with op 10 and mask 8'h0F.
- Cycle c: grant=4'b0001.
- Cycle c+1: busy=1, j_drv=8'h0F, k_drv=8'h00.
- Cycle c+2: q=8'h0F, busy=0.
REQ-027 Toggle, clear and hold, starting from q=8'h0F:
- req1 op 11, mask 8'hFF -> q=8'hF0.
- Then req3 op 01, mask 8'h90 -> q=8'h60.
- Then req2 op 10, mask 8'h00 -> q=8'h60 unchanged, and the grant is still issued.
REQ-028 Fairness: after reset, req=4'b1111 held, with each requester dropping req after its grant.
- Grants 0001, 0010, 0100, 1000 in cycles c, c+2, c+4, c+6.
- Then re-raise req0 and req2 with p=0 -> next grants are 0001 then 0100.
REQ-029 Reset mid-operation: grant req0 op 11, mask 8'hFF from q=8'hAA; assert rst in the APPLY cycle.
- Next cycle: q=8'h00, busy=0.
- With req=4'b0110 after release -> first grant is 4'b0010.
REQ-030 Simultaneous arrival during APPLY: req2 rises in the APPLY cycle of a req1 command. req2 is granted in the following IDLE cycle and its effect is applied after req1's effect.
